// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// aes_inv_cipher_ctrl_pkg: shared types, constants and inverse-round byte transforms
package aes_inv_cipher_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    localparam int BLOCK_W = 128;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // Inverse S-box, entry b at bits [8*b +: 8]
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is a constant at every call site, so the unused terms fold away
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates right by r
    function automatic logic [0:BLOCK_W-1] inv_shift_rows(input logic [0:BLOCK_W-1] s);
        logic [0:BLOCK_W-1] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
        return o;
    endfunction

    function automatic logic [0:BLOCK_W-1] inv_sub_bytes(input logic [0:BLOCK_W-1] s);
        logic [0:BLOCK_W-1] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = INV_SBOX[8*s[8*k +: 8] +: 8];
        return o;
    endfunction

    function automatic logic [0:BLOCK_W-1] inv_mix_columns(input logic [0:BLOCK_W-1] s);
        logic [0:BLOCK_W-1] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            o[32*c+8 +: 8]  = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            o[32*c+16 +: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            o[32*c+24 +: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// aes_inv_cipher_ctrl_if: block input/output handshakes plus the round-key fetch port
interface aes_inv_cipher_ctrl_if;
    import aes_inv_cipher_ctrl_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [0:BLOCK_W-1] in_data;
    logic [3:0]         rk_idx;
    logic [0:BLOCK_W-1] round_key;
    logic               out_valid;
    logic               out_ready;
    logic [0:BLOCK_W-1] out_data;
    logic               busy;

    modport slave (
        input  in_valid, in_data, round_key, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, round_key, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_inv_cipher_ctrl_inv_round.sv
// aes_inv_round: combinational AES inverse round; skip_mix_i drops InvMixColumns for the last round
module aes_inv_round
    import aes_inv_cipher_ctrl_pkg::*;
(
    input  logic [0:BLOCK_W-1] state_i,
    input  logic [0:BLOCK_W-1] round_key_i,
    input  logic               skip_mix_i,
    output logic [0:BLOCK_W-1] state_o
);

    logic [0:BLOCK_W-1] keyed;

    assign keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
    assign state_o = skip_mix_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES inverse cipher, one round per clock over a shared round datapath
module aes_inv_cipher_ctrl
    import aes_inv_cipher_ctrl_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_inv_cipher_ctrl_if.slave   bus
);

    localparam int NR = nr_of(NK);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_inv_cipher_ctrl: NK must be 4, 6 or 8");
    end

    state_e             state_q, state_d;
    logic [0:BLOCK_W-1] sreg_q, sreg_d;
    logic [3:0]         round_q, round_d;
    logic [0:BLOCK_W-1] round_out;

    aes_inv_round u_round (
        .state_i     (sreg_q),
        .round_key_i (bus.round_key),
        .skip_mix_i  (state_q == FINAL),
        .state_o     (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = ROUND;
                sreg_d  = bus.in_data ^ bus.round_key;
                round_d = 4'(NR - 1);
            end
            ROUND: begin
                state_d = (round_q == 4'd1) ? FINAL : ROUND;
                sreg_d  = round_out;
                round_d = round_q - 4'd1;
            end
            FINAL: begin
                state_d = DONE;
                sreg_d  = round_out;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
        endcase
    end

    // Key index depends only on registers, so the key store may answer combinationally
    assign bus.rk_idx    = (state_q == ROUND) ? round_q : (state_q == FINAL) ? 4'd0 : 4'(NR);
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data  = (state_q == DONE) ? sreg_q : '0;
    assign bus.busy      = (state_q == ROUND) || (state_q == FINAL);

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: FIPS-197 vectors on AES-128/192/256 instances plus handshake corner cases
module tb_aes_inv_cipher_ctrl;

    typedef struct {
        int           g;
        logic [127:0] ct;
        logic [127:0] pt;
        int           poke;
    } vec_t;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid [3];
    logic         out_ready [3];
    logic [127:0] in_data [3];
    logic         in_ready [3];
    logic         out_valid [3];
    logic         busy [3];
    logic [3:0]   rk_idx [3];
    logic [127:0] out_data [3];
    logic [127:0] rks [3][16];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : inst
        aes_inv_cipher_ctrl_if bus ();
        aes_inv_cipher_ctrl #(.NK(4 + 2*g)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
        assign bus.in_valid    = in_valid[g];
        assign bus.in_data     = in_data[g];
        assign bus.out_ready   = out_ready[g];
        assign bus.round_key   = rks[g][bus.rk_idx];
        assign in_ready[g]     = bus.in_ready;
        assign out_valid[g]    = bus.out_valid;
        assign busy[g]         = bus.busy;
        assign rk_idx[g]       = bus.rk_idx;
        assign out_data[g]     = bus.out_data;
    end

    function automatic logic [7:0] xtb(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtb(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: x^254 inverse, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gm(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input int g);
        int nk = 4 + 2*g;
        int nr = nk + 6;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtb(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rks[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Offers ct until accepted, then counts edges to out_valid while checking rk_idx each cycle
    task automatic run(input int g, input logic [127:0] ct, input int poke,
                       output logic [127:0] pt, output int lat, output bit rk_ok, output int acc);
        int nr = 10 + 2*g;
        int w = 0;
        in_valid[g] = 1'b1;
        in_data[g]  = ct;
        while (!in_ready[g] && w < 20) begin
            step();
            w++;
        end
        rk_ok = (rk_idx[g] == 4'(nr));
        step();
        acc = cyc;
        in_valid[g] = 1'b0;
        in_data[g]  = '0;
        lat = 0;
        while (!out_valid[g] && lat < 40) begin
            if (rk_idx[g] != 4'(nr - 1 - lat)) rk_ok = 1'b0;
            in_valid[g] = (lat == poke);
            in_data[g]  = (lat == poke) ? ~ct : '0;
            step();
            lat++;
        end
        in_valid[g] = 1'b0;
        pt = out_data[g];
    endtask

    initial begin
        vec_t         vecs [4];
        logic [127:0] pt, pt2, d0;
        int           lat, acc, acc2, n, stale;
        bit           rk_ok, stable;
        vecs[0] = '{0, CT4, PT, -1};
        vecs[1] = '{1, CT6, PT, -1};
        vecs[2] = '{2, CT8, PT, -1};
        vecs[3] = '{0, CT4, PT, 3};
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b1;
            expand(g);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("reset in_ready", 128'(in_ready[0]), 128'd1);
        chk("reset out_valid", 128'(out_valid[0]), 128'd0);
        chk("reset out_data", out_data[0], 128'd0);
        chk("reset busy", 128'(busy[0]), 128'd0);
        chk("reset rk_idx nk4", 128'(rk_idx[0]), 128'd10);
        chk("reset rk_idx nk8", 128'(rk_idx[2]), 128'd14);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run(vecs[i].g, vecs[i].ct, vecs[i].poke, pt, lat, rk_ok, acc);
            chk($sformatf("vec%0d plaintext", i), pt, vecs[i].pt);
            chk($sformatf("vec%0d latency", i), 128'(lat), 128'(10 + 2*vecs[i].g));
            chk($sformatf("vec%0d rk_idx seq", i), 128'(rk_ok), 128'd1);
            step();
        end

        run(0, CT4, -1, pt, lat, rk_ok, acc);
        run(0, CT4, -1, pt2, lat, rk_ok, acc2);
        chk("b2b first", pt, PT);
        chk("b2b second", pt2, PT);
        chk("b2b accept gap", 128'(acc2 - acc), 128'd12);
        step();

        out_ready[0] = 1'b0;
        run(0, CT4, -1, pt, lat, rk_ok, acc);
        d0 = out_data[0];
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
            step();
            if (out_data[0] !== d0 || in_ready[0] || busy[0] || !out_valid[0]) stable = 1'b0;
        end
        chk("stall data", d0, PT);
        chk("stall stable", 128'(stable), 128'd1);
        out_ready[0] = 1'b1;
        in_data[0]   = CT4;
        chk("done in_ready", 128'(in_ready[0]), 128'd0);
        step();
        chk("idle in_ready", 128'(in_ready[0]), 128'd1);
        chk("idle out_valid", 128'(out_valid[0]), 128'd0);
        chk("idle out_data", out_data[0], 128'd0);
        step();
        chk("late accept busy", 128'(busy[0]), 128'd1);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            step();
            n++;
        end
        chk("late accept latency", 128'(n), 128'd10);
        chk("late accept plaintext", out_data[0], PT);
        step();

        in_valid[0] = 1'b1;
        in_data[0]  = CT4;
        step();
        in_valid[0] = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midop out_valid", 128'(out_valid[0]), 128'd0);
        chk("midop in_ready", 128'(in_ready[0]), 128'd1);
        chk("midop busy", 128'(busy[0]), 128'd0);
        chk("midop rk_idx", 128'(rk_idx[0]), 128'd10);
        chk("midop out_data", out_data[0], 128'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        stale = 0;
        repeat (15) begin
            step();
            if (out_valid[0]) stale++;
        end
        chk("no stale out_valid", 128'(stale), 128'd0);
        run(0, CT4, -1, pt, lat, rk_ok, acc);
        chk("rerun plaintext", pt, PT);
        chk("rerun latency", 128'(lat), 128'd10);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher sequencer: one decryption round per clock over a shared combinational inverse-round datapath (inv_shift_rows, inv_sub_bytes, add-round-key, inv_mix_columns).
- Accepts one 128-bit ciphertext block and fetches round keys from an external key-schedule store by index.
- Returns the plaintext block.
- Sits between the key-expansion memory and the block-level decrypt wrapper.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4/6/8 (AES-128/192/256).
- NR, NK+6, number of rounds; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  controller can accept a block
- in_data  in  [0:127]  ciphertext; bit 0 = MSB of byte 0
- rk_idx  out  4  round-key index requested this cycle
- round_key  in  [0:127]  key for rk_idx, valid combinationally in the same cycle
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  [0:127]  plaintext, same bit order as in_data
- busy  out  1  high in ROUND or FINAL

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, state_reg=0, round=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0, rk_idx=NR.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid&in_ready: state_reg <= in_data ^ round_key, round <= NR-1, go ROUND.
- ROUND:
  - rk_idx=round.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ round_key).
  - If round==1, go FINAL with round <= 0; otherwise round <= round-1.
- FINAL:
  - rk_idx=0.
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ round_key.
  - Go DONE.
- DONE:
  - out_valid=1, out_data=state_reg.
  - On out_ready: go IDLE.
  - out_data holds stable while out_valid=1 and out_ready=0, for unlimited stall.
- in_ready is high only in IDLE. Inputs offered in other states are ignored and not latched; in_data is sampled only on the accept edge.
- Latency: out_valid rises after exactly NR rising edges following the accept edge (AES-128: 10).
- Throughput: one block per NR+2 cycles with out_ready tied high.
- out_valid&out_ready and in_valid in the same DONE cycle: only the output completes; the new input is accepted next cycle in IDLE.
- out_data returns to 0 in IDLE. It is only meaningful while out_valid=1.
- rk_idx is a registered function of state/round; round_key must settle within the same cycle.
- Reset asserted mid-operation: immediate return to reset values; the block in flight is discarded and no partial out_valid is produced.
- The round counter never wraps. round==0 appears only in FINAL.
- Illegal NK: elaboration error.

Decomposition:
- Shared include aes_defs.vh holds:
  - state encoding (IDLE, ROUND, FINAL, DONE, 2 bits)
  - NR derivation macro
  - block-width constant 128
- One natural sub-module, aes_inv_round: a combinational inverse round that instantiates inv_shift_rows, inv_sub_bytes and inv_mix_columns, with a skip_mix input (high in FINAL).
- The controller holds the FSM, counter, state register and handshake only.

Test Plan:
1. NK=4, round keys from FIPS-197 C.1 key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff; out_valid exactly 10 edges after accept; rk_idx sequence 10,9,...,1,0.
2. NK=6, key 000102...1617, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 12 edges. NK=8, key 000102...1e1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 14 edges.
3. Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, busy=0; a new in_valid is not accepted until the cycle after out_ready=1.
4. in_valid pulsed high with new data during ROUND -> ignored; the result still equals case 1. Two back-to-back blocks with out_ready=1 -> both correct, accept edges NR+2 cycles apart.
5. rst_n driven low at round 5 of case 1 -> outputs return to reset values asynchronously (before the next clk edge). After release, case 1 rerun gives the correct plaintext with no stale out_valid.
